floor_call_panel: RTL and testbench

//  Request-issuing side of the elevator car interface. Latches hall/car call buttons into a pending map and drives one

---
 rtl/floor_call_panel_pkg.sv | 32 +++
 rtl/floor_call_panel_if.sv | 27 ++
 rtl/floor_call_panel_call_select.sv | 71 +++++++
 rtl/floor_call_panel.sv | 152 +++++++++++++++
 tb/tb_floor_call_panel.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/floor_call_panel_pkg.sv
// Shared types and constants for the floor call panel: floor numbering,
// pending-call map, travel direction and panel FSM states.
// No logic; imported by the interface, the selector and the panel top.
package elevator_pkg;

    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = $clog2(NUM_FLOORS);

    typedef logic [FLOOR_W-1:0]    floor_t;
    typedef logic [NUM_FLOORS-1:0] floor_map_t;

    // The car controller reads floor 0 as "no request".
    localparam floor_t FLOOR_NONE = '0;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        WAIT_ACK,
        WAIT_DONE
    } panel_state_t;

    // One-hot map with only floor f set.
    function automatic floor_map_t floor_bit(input floor_t f);
        return floor_map_t'(1) << f;
    endfunction

endpackage

// File: rtl/floor_call_panel_if.sv
// Signal bundle between the call panel, the button/lamp I/O and the car controller.
// master = call panel (drives req_floor, lamp, busy, arrive, stall);
// slave  = the I/O and controller side (drives button, complete, out_floor, over_weight).
interface floor_call_panel_if;
    import elevator_pkg::*;

    floor_map_t button;       // call buttons, level
    logic       complete;     // 1 = car idle/arrived, 0 = travelling
    floor_t     out_floor;    // car's current floor
    logic       over_weight;  // car held by overload
    floor_t     req_floor;    // requested floor, FLOOR_NONE = no request
    floor_map_t lamp;         // registered-call lamps
    logic       busy;         // panel FSM not idle
    logic       arrive;       // one-cycle pulse when a call is served
    logic       stall;        // one-cycle pulse on watchdog expiry

    modport master (
        input  button, complete, out_floor, over_weight,
        output req_floor, lamp, busy, arrive, stall
    );

    modport slave (
        output button, complete, out_floor, over_weight,
        input  req_floor, lamp, busy, arrive, stall
    );

endinterface

// File: rtl/floor_call_panel_call_select.sv
// Purpose: picks the next floor to serve from the pending map, sweep order.
// Latency: purely combinational.
// Backpressure: none; the panel samples the result only in its SELECT state.
// Ports: i_lamp (pending map), i_out_floor (car position), i_dir (current sweep)
//        -> o_target, o_found, o_new_dir (sweep after a possible reversal),
//           o_here (the only pending call is at the car's floor).
module call_select
    import elevator_pkg::*;
(
    input  floor_map_t i_lamp,
    input  floor_t     i_out_floor,
    input  dir_t       i_dir,
    output floor_t     o_target,
    output logic       o_found,
    output dir_t       o_new_dir,
    output logic       o_here
);

    logic   w_above_found;
    logic   w_below_found;
    floor_t w_above;
    floor_t w_below;

    // Nearest pending floor strictly above and strictly below the car.
    // Descending scan leaves the lowest hit above; ascending leaves the highest below.
    always_comb begin
        w_above_found = 1'b0;
        w_above       = FLOOR_NONE;
        for (int i = NUM_FLOORS - 1; i >= 1; i--) begin
            if (i_lamp[i] && (floor_t'(i) > i_out_floor)) begin
                w_above_found = 1'b1;
                w_above       = floor_t'(i);
            end
        end
        w_below_found = 1'b0;
        w_below       = FLOOR_NONE;
        for (int i = 1; i < NUM_FLOORS; i++) begin
            if (i_lamp[i] && (floor_t'(i) < i_out_floor)) begin
                w_below_found = 1'b1;
                w_below       = floor_t'(i);
            end
        end
    end

    always_comb begin
        o_here    = (i_lamp == floor_bit(i_out_floor));
        o_found   = 1'b0;
        o_target  = FLOOR_NONE;
        o_new_dir = i_dir;
        if (i_dir == DIR_UP) begin
            if (w_above_found) begin
                o_found  = 1'b1;
                o_target = w_above;
            end else if (w_below_found) begin
                o_found   = 1'b1;
                o_target  = w_below;
                o_new_dir = DIR_DOWN;
            end
        end else begin
            if (w_below_found) begin
                o_found  = 1'b1;
                o_target = w_below;
            end else if (w_above_found) begin
                o_found   = 1'b1;
                o_target  = w_above;
                o_new_dir = DIR_UP;
            end
        end
    end

endmodule

// File: rtl/floor_call_panel.sv
// Purpose: latches call buttons into a pending map and issues one floor request at a time to the car.
// Latency: press to req_floor is 3 cycles from IDLE (edge detect into lamp, IDLE->SELECT, SELECT->WAIT_ACK).
// Backpressure: over_weight blocks new requests and freezes WAIT states; presses still latch.
// Ports: clk, rst (sync, active high); bus (floor_call_panel_if.master): button, complete, out_floor,
//        over_weight in; req_floor, lamp, busy, arrive, stall out.
// Optional: define CALL_PANEL_WDOG_EN to add a WD_CYCLES watchdog on WAIT states that abandons
//           the trip (lamp kept, so the call is retried) and pulses stall; otherwise stall is 0.
module floor_call_panel
    import elevator_pkg::*;
`ifdef CALL_PANEL_WDOG_EN
#(
    parameter int WD_CYCLES = 1024
)
`endif
(
    input  logic               clk,
    input  logic               rst,
    floor_call_panel_if.master bus
);

    panel_state_t r_state;
    dir_t         r_dir;
    floor_map_t   r_lamp;
    floor_map_t   r_btn_prev;
    floor_t       r_target;
    floor_t       r_req;
    logic         r_arrive;

    floor_t       w_sel_target;
    logic         w_sel_found;
    dir_t         w_sel_dir;
    logic         w_sel_here;
    floor_map_t   w_press;
    floor_map_t   w_clear;
    logic         w_done;

    call_select u_call_select (
        .i_lamp      (r_lamp),
        .i_out_floor (bus.out_floor),
        .i_dir       (r_dir),
        .o_target    (w_sel_target),
        .o_found     (w_sel_found),
        .o_new_dir   (w_sel_dir),
        .o_here      (w_sel_here)
    );

    // Rising edges only; floor 0 is never a real call.
    assign w_press = bus.button & ~r_btn_prev & ~floor_map_t'(1);

    assign w_done = (r_state == WAIT_DONE) && !bus.over_weight &&
                    bus.complete && (bus.out_floor == r_target);

    // Clear is applied before the OR with w_press, so a press in the clear cycle keeps the lamp lit.
    always_comb begin
        w_clear = '0;
        if ((r_state == SELECT) && w_sel_here) begin
            w_clear = floor_bit(bus.out_floor);
        end else if (w_done) begin
            w_clear = floor_bit(r_target);
        end
    end

`ifdef CALL_PANEL_WDOG_EN
    localparam int WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_stall;
    logic            w_wd_expire;

    assign w_wd_expire = (r_wd_cnt == WD_W'(WD_CYCLES - 1));
    assign bus.stall   = r_stall;
`else
    assign bus.stall   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dir      <= DIR_UP;
            r_lamp     <= '0;
            r_btn_prev <= '0;
            r_target   <= FLOOR_NONE;
            r_req      <= FLOOR_NONE;
            r_arrive   <= 1'b0;
`ifdef CALL_PANEL_WDOG_EN
            r_wd_cnt   <= '0;
            r_stall    <= 1'b0;
`endif
        end else begin
            r_btn_prev <= bus.button;
            r_lamp     <= (r_lamp & ~w_clear) | w_press;
            r_arrive   <= 1'b0;
`ifdef CALL_PANEL_WDOG_EN
            r_stall    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    r_req <= FLOOR_NONE;
                    if ((r_lamp != '0) && !bus.over_weight) begin
                        r_state <= SELECT;
                    end
                end
                SELECT: begin
                    if (w_sel_here) begin
                        // Call at the car's own floor: served without a request.
                        r_arrive <= 1'b1;
                        r_state  <= IDLE;
                    end else if (w_sel_found) begin
                        r_target <= w_sel_target;
                        r_req    <= w_sel_target;
                        r_dir    <= w_sel_dir;
                        r_state  <= WAIT_ACK;
`ifdef CALL_PANEL_WDOG_EN
                        r_wd_cnt <= '0;
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT_ACK, WAIT_DONE: begin
                    if (!bus.over_weight) begin
                        if (w_done) begin
                            r_arrive <= 1'b1;
                            r_req    <= FLOOR_NONE;
                            r_state  <= IDLE;
`ifdef CALL_PANEL_WDOG_EN
                        end else if (w_wd_expire) begin
                            // Abandon the trip; the lamp stays set so IDLE retries it.
                            r_stall <= 1'b1;
                            r_req   <= FLOOR_NONE;
                            r_state <= IDLE;
`endif
                        end else begin
                            if ((r_state == WAIT_ACK) && !bus.complete) begin
                                r_state <= WAIT_DONE;
                            end
`ifdef CALL_PANEL_WDOG_EN
                            r_wd_cnt <= r_wd_cnt + WD_W'(1);
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_floor = r_req;
    assign bus.lamp      = r_lamp;
    assign bus.busy      = (r_state != IDLE);
    assign bus.arrive    = r_arrive;

endmodule

// File: tb/tb_floor_call_panel.sv
module tb_floor_call_panel;
    import elevator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference model: set of pending floors and the sweep direction.
    bit   m_pend [NUM_FLOORS];
    bit   m_up;

    floor_call_panel_if bus_if ();

`ifdef CALL_PANEL_WDOG_EN
    floor_call_panel #(.WD_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus_if));
`else
    floor_call_panel dut (.clk(clk), .rst(rst), .bus(bus_if));
`endif

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic floor_map_t mdl_lamp();
        floor_map_t m = '0;
        for (int f = 1; f < NUM_FLOORS; f++) m[f] = m_pend[f];
        return m;
    endfunction

    function automatic void mdl_add(input floor_map_t m);
        for (int f = 1; f < NUM_FLOORS; f++) if (m[f]) m_pend[f] = 1'b1;
    endfunction

    // Next floor by the sweep rule; returns cur when it is the only pending call.
    function automatic int pick(input int cur);
        int n = 0;
        for (int f = 1; f < NUM_FLOORS; f++) if (m_pend[f]) n++;
        if (n == 0) return -1;
        if (n == 1 && m_pend[cur]) return cur;
        if (m_up) begin
            for (int f = cur + 1; f < NUM_FLOORS; f++) if (m_pend[f]) return f;
            m_up = 1'b0;
            for (int f = cur - 1; f >= 1; f--) if (m_pend[f]) return f;
        end else begin
            for (int f = cur - 1; f >= 1; f--) if (m_pend[f]) return f;
            m_up = 1'b1;
            for (int f = cur + 1; f < NUM_FLOORS; f++) if (m_pend[f]) return f;
        end
        return -1;
    endfunction

    task automatic do_reset(input int floor);
        bus_if.button      = '0;
        bus_if.complete    = 1'b1;
        bus_if.out_floor   = floor_t'(floor);
        bus_if.over_weight = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) m_pend[f] = 1'b0;
        m_up = 1'b1;
    endtask

    task automatic press(input floor_map_t m);
        bus_if.button = m;
        tick();
        bus_if.button = '0;
    endtask

    task automatic wait_req(output int f, output bit ok);
        ok = 1'b0;
        f  = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_if.req_floor != FLOOR_NONE) begin
                ok = 1'b1;
                f  = int'(bus_if.req_floor);
                break;
            end
        end
    endtask

    // Acts as the car: leave, travel a while (optionally with a mid-trip press), arrive at tgt.
    task automatic finish_trip(input int tgt, input floor_map_t extra, output bit arr, output floor_map_t lamp_after);
        bus_if.complete = 1'b0;
        tick();
        bus_if.button = extra;
        tick();
        bus_if.button = '0;
        repeat ($urandom_range(1, 3)) tick();
        bus_if.out_floor = floor_t'(tgt);
        bus_if.complete  = 1'b1;
        tick();
        arr        = bus_if.arrive;
        lamp_after = bus_if.lamp;
    endtask

    task automatic test_reset();
        do_reset(0);
        checks++; if (bus_if.req_floor !== FLOOR_NONE) begin errors++; $display("FAIL reset_req: got %0d want 0", bus_if.req_floor); end
        checks++; if (bus_if.lamp !== 8'h00) begin errors++; $display("FAIL reset_lamp: got %h want 00", bus_if.lamp); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
        checks++; if (bus_if.arrive !== 1'b0) begin errors++; $display("FAIL reset_arrive: got %b want 0", bus_if.arrive); end
        checks++; if (bus_if.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus_if.stall); end
    endtask

    task automatic test_single_call();
        bit stable = 1'b1;
        do_reset(1);
        bus_if.button = 8'h20;
        tick();
        bus_if.button = '0;
        checks++; if (bus_if.lamp !== 8'h20) begin errors++; $display("FAIL single_lamp: got %h want 20", bus_if.lamp); end
        checks++; if (bus_if.req_floor !== FLOOR_NONE) begin errors++; $display("FAIL single_req_early1: got %0d want 0", bus_if.req_floor); end
        tick();
        checks++; if (bus_if.req_floor !== FLOOR_NONE) begin errors++; $display("FAIL single_req_early2: got %0d want 0", bus_if.req_floor); end
        tick();
        checks++; if (bus_if.req_floor !== 3'd5) begin errors++; $display("FAIL single_req_latency: got %0d want 5", bus_if.req_floor); end
        bus_if.complete = 1'b0;
        repeat (4) begin
            tick();
            if (bus_if.req_floor !== 3'd5 || bus_if.busy !== 1'b1 || bus_if.arrive !== 1'b0) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL single_travel_hold: got req %0d busy %b want 5 1", bus_if.req_floor, bus_if.busy); end
        bus_if.out_floor = 3'd5;
        bus_if.complete  = 1'b1;
        tick();
        checks++; if ({bus_if.arrive, bus_if.lamp, bus_if.req_floor} !== {1'b1, 8'h00, 3'd0}) begin
            errors++; $display("FAIL single_arrive: got arrive %b lamp %h req %0d want 1 00 0", bus_if.arrive, bus_if.lamp, bus_if.req_floor);
        end
        tick();
        checks++; if (bus_if.arrive !== 1'b0) begin errors++; $display("FAIL single_arrive_pulse: got %b want 0", bus_if.arrive); end
    endtask

    task automatic test_sweep_order();
        int exp_order [3] = '{4, 6, 2};
        int got;
        bit ok, arr;
        floor_map_t la;
        do_reset(3);
        press(8'h54);
        for (int k = 0; k < 3; k++) begin
            wait_req(got, ok);
            checks++; if (!ok || got != exp_order[k]) begin errors++; $display("FAIL sweep_target%0d: got %0d want %0d", k, got, exp_order[k]); end
            finish_trip(exp_order[k], '0, arr, la);
            checks++; if (!arr) begin errors++; $display("FAIL sweep_arrive%0d: got %b want 1", k, arr); end
        end
        checks++; if (bus_if.lamp !== 8'h00) begin errors++; $display("FAIL sweep_lamp_empty: got %h want 00", bus_if.lamp); end
    endtask

    task automatic test_here();
        do_reset(4);
        press(8'h10);
        tick();
        checks++; if (bus_if.arrive !== 1'b0 || bus_if.req_floor !== FLOOR_NONE) begin
            errors++; $display("FAIL here_select: got arrive %b req %0d want 0 0", bus_if.arrive, bus_if.req_floor);
        end
        tick();
        checks++; if ({bus_if.arrive, bus_if.lamp, bus_if.req_floor, bus_if.busy} !== {1'b1, 8'h00, 3'd0, 1'b0}) begin
            errors++; $display("FAIL here_arrive: got arrive %b lamp %h req %0d busy %b want 1 00 0 0", bus_if.arrive, bus_if.lamp, bus_if.req_floor, bus_if.busy);
        end
    endtask

    task automatic test_floor0();
        bit seen = 1'b0;
        do_reset(2);
        press(8'h01);
        repeat (4) begin
            if (bus_if.lamp != 8'h00 || bus_if.busy) seen = 1'b1;
            tick();
        end
        checks++; if (seen) begin errors++; $display("FAIL floor0_ignored: got lamp %h busy %b want 00 0", bus_if.lamp, bus_if.busy); end
    endtask

    task automatic test_overweight();
        int got;
        bit ok;
        bit stable = 1'b1;
        do_reset(1);
        bus_if.over_weight = 1'b1;
        press(8'h80);
        repeat (4) tick();
        checks++; if (bus_if.busy !== 1'b0 || bus_if.lamp !== 8'h80) begin
            errors++; $display("FAIL ow_blocks_idle: got busy %b lamp %h want 0 80", bus_if.busy, bus_if.lamp);
        end
        bus_if.over_weight = 1'b0;
        wait_req(got, ok);
        checks++; if (!ok || got != 7) begin errors++; $display("FAIL ow_req: got %0d want 7", got); end
        bus_if.complete = 1'b0;
        tick();
        tick();
        bus_if.over_weight = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus_if.out_floor = 3'd7;
                bus_if.complete  = 1'b1;
            end
            tick();
            if (bus_if.req_floor !== 3'd7 || bus_if.arrive !== 1'b0 || bus_if.busy !== 1'b1) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL ow_hold: got req %0d arrive %b want 7 0", bus_if.req_floor, bus_if.arrive); end
        bus_if.over_weight = 1'b0;
        tick();
        checks++; if (bus_if.arrive !== 1'b1 || bus_if.lamp !== 8'h00) begin
            errors++; $display("FAIL ow_served: got arrive %b lamp %h want 1 00", bus_if.arrive, bus_if.lamp);
        end
    endtask

    task automatic test_press_on_clear();
        int got;
        bit ok;
        bit arr = 1'b0;
        bit req_seen = 1'b0;
        do_reset(1);
        press(8'h40);
        wait_req(got, ok);
        checks++; if (!ok || got != 6) begin errors++; $display("FAIL poc_req: got %0d want 6", got); end
        bus_if.complete = 1'b0;
        tick();
        tick();
        bus_if.out_floor = 3'd6;
        bus_if.complete  = 1'b1;
        bus_if.button    = 8'h40;
        tick();
        bus_if.button = '0;
        checks++; if (bus_if.arrive !== 1'b1 || bus_if.lamp !== 8'h40) begin
            errors++; $display("FAIL poc_new_call_wins: got arrive %b lamp %h want 1 40", bus_if.arrive, bus_if.lamp);
        end
        for (int i = 0; i < 4 && !arr; i++) begin
            tick();
            if (bus_if.req_floor != FLOOR_NONE) req_seen = 1'b1;
            if (bus_if.arrive) arr = 1'b1;
        end
        checks++; if (!arr || req_seen || bus_if.lamp !== 8'h00) begin
            errors++; $display("FAIL poc_reserved: got arrive %b req_seen %b lamp %h want 1 0 00", arr, req_seen, bus_if.lamp);
        end
    endtask

    task automatic test_reset_mid();
        int got;
        bit ok;
        do_reset(3);
        press(8'hA4);
        wait_req(got, ok);
        checks++; if (!ok || got != 5) begin errors++; $display("FAIL rmid_req: got %0d want 5", got); end
        bus_if.complete = 1'b0;
        tick();
        tick();
        checks++; if (bus_if.lamp !== 8'hA4) begin errors++; $display("FAIL rmid_lamp: got %h want a4", bus_if.lamp); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus_if.req_floor, bus_if.lamp, bus_if.busy, bus_if.arrive, bus_if.stall} !== 14'd0) begin
            errors++; $display("FAIL rmid_outputs: got req %0d lamp %h busy %b arrive %b stall %b want all 0",
                               bus_if.req_floor, bus_if.lamp, bus_if.busy, bus_if.arrive, bus_if.stall);
        end
        bus_if.complete = 1'b1;
        repeat (3) tick();
        checks++; if (bus_if.lamp !== 8'h00 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL rmid_dropped: got lamp %h busy %b want 00 0", bus_if.lamp, bus_if.busy);
        end
    endtask

    task automatic test_random();
        int cur, exp_f, got, guard;
        bit ok, arr, req_seen;
        floor_map_t mask, extra, la;
        cur = $urandom_range(1, NUM_FLOORS - 1);
        do_reset(cur);
        for (int it = 0; it < 25; it++) begin
            mask = floor_map_t'($urandom_range(0, 255));
            press(mask);
            mdl_add(mask);
            checks++; if (bus_if.lamp !== mdl_lamp()) begin errors++; $display("FAIL rnd_press_lamp it%0d: got %h want %h", it, bus_if.lamp, mdl_lamp()); end
            guard = 0;
            while (mdl_lamp() != '0 && guard < 16) begin
                guard++;
                exp_f = pick(cur);
                if (exp_f == cur) begin
                    arr = 1'b0;
                    req_seen = 1'b0;
                    for (int i = 0; i < 6 && !arr; i++) begin
                        tick();
                        if (bus_if.req_floor != FLOOR_NONE) req_seen = 1'b1;
                        if (bus_if.arrive) arr = 1'b1;
                    end
                    m_pend[cur] = 1'b0;
                    checks++; if (!arr || req_seen) begin errors++; $display("FAIL rnd_here it%0d: got arrive %b req_seen %b want 1 0", it, arr, req_seen); end
                end else begin
                    wait_req(got, ok);
                    checks++; if (!ok || got != exp_f) begin errors++; $display("FAIL rnd_target it%0d: got %0d want %0d", it, got, exp_f); end
                    extra = ($urandom_range(0, 2) == 0) ? floor_map_t'($urandom_range(0, 255)) : '0;
                    finish_trip(exp_f, extra, arr, la);
                    mdl_add(extra);
                    m_pend[exp_f] = 1'b0;
                    cur = exp_f;
                    checks++; if (!arr || la !== mdl_lamp()) begin errors++; $display("FAIL rnd_served it%0d: got arrive %b lamp %h want 1 %h", it, arr, la, mdl_lamp()); end
                end
            end
        end
    endtask

`ifdef CALL_PANEL_WDOG_EN
    task automatic test_watchdog();
        int got, n;
        bit ok, arr;
        floor_map_t la;
        do_reset(1);
        press(8'h08);
        wait_req(got, ok);
        checks++; if (!ok || got != 3) begin errors++; $display("FAIL wd_req: got %0d want 3", got); end
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (bus_if.stall) break;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL wd_stall_cycle: got %0d want 16", n); end
        checks++; if (bus_if.lamp[3] !== 1'b1 || bus_if.req_floor !== FLOOR_NONE) begin
            errors++; $display("FAIL wd_lamp_kept: got lamp %h req %0d want bit3 set, req 0", bus_if.lamp, bus_if.req_floor);
        end
        wait_req(got, ok);
        checks++; if (!ok || got != 3) begin errors++; $display("FAIL wd_retry: got %0d want 3", got); end
        finish_trip(3, '0, arr, la);
        checks++; if (!arr || la !== 8'h00) begin errors++; $display("FAIL wd_retry_served: got arrive %b lamp %h want 1 00", arr, la); end
    endtask
`endif

    initial begin
        bus_if.button      = '0;
        bus_if.complete    = 1'b1;
        bus_if.out_floor   = '0;
        bus_if.over_weight = 1'b0;
        test_reset();
        test_single_call();
        test_sweep_order();
        test_here();
        test_floor0();
        test_overweight();
        test_press_on_clear();
        test_reset_mid();
        test_random();
`ifdef CALL_PANEL_WDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
